playback_sequencer: RTL and testbench
=====================================

Name: playback_sequencer

Overview:
- Parametrised next-generation playback engine. Walks a recorded region of sample memory from StartAddr to EndAddr.
- Each memory word is {sample, repeat count}. The sample is emitted once per playback tick, count times, then the sequencer advances to the next word.
- Adds start/stop control, one-shot or loop mode, tick-paced output with a valid strobe, and Busy/Done status.
- Sits between the recording memory (synchronous read, 1-cycle latency) and the tone/PBK output stage.

Parameters:
- DATA_W, 8: sample width (upper field of memory word).
- CNT_W, 4: repeat-count width (lower field of memory word).
- ADDR_W, 11: memory address width.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PBrst  in  1  reset, synchronous, active-high.
- Play  in  1  start request (level sampled each cycle).
- Stop  in  1  abort request.
- Loop  in  1  1 = restart at StartAddr after EndAddr; 0 = one-shot.
- TickEn  in  1  playback-rate tick; one count consumed per tick.
- StartAddr  in  ADDR_W  first word of region; sampled on accepted Play and on loop restart.
- EndAddr  in  ADDR_W  last word of region (inclusive); sampled in ADVANCE.
- SignalFromMem  in  DATA_W+CNT_W  read data: [DATA_W+CNT_W-1:CNT_W] = sample, [CNT_W-1:0] = count.
- Address  out  ADDR_W  registered memory read address.
- PBK  out  DATA_W  registered sample output; holds between emissions.
- PBKValid  out  1  one-cycle pulse, high in the cycle PBK is updated.
- Busy  out  1  high whenever the state is not IDLE.
- Done  out  1  one-cycle pulse when one-shot playback completes.

Behaviour:
- Reset: state = IDLE; Address, PBK, count register and sample register = 0; PBKValid = Busy = Done = 0.
- Priority, every cycle: PBrst > Stop > normal FSM.
- Stop in any non-IDLE state: next state is IDLE, no PBKValid, no Done. PBK and Address hold.
- PBKValid and Done default to 0 in every cycle unless set below.
- States:
  - IDLE: if Play && !Stop, then Address <= StartAddr and go to FETCH. Otherwise stay.
  - FETCH: single wait cycle for memory latency, then go to LOAD.
  - LOAD: capture the sample and count fields from SignalFromMem. If count == 0, go to ADVANCE (zero-count word is skipped, nothing emitted). Otherwise go to PLAY. TickEn is ignored.
  - PLAY: on TickEn, PBK <= captured sample, PBKValid <= 1, count <= count-1. If the pre-decrement count == 1, go to ADVANCE; otherwise stay. Without TickEn, hold.
  - ADVANCE:
    - If Address == EndAddr and Loop = 1: Address <= StartAddr, go to FETCH.
    - If Address == EndAddr and Loop = 0: Done <= 1, go to IDLE.
    - Otherwise: Address <= Address+1 (modulo 2^ADDR_W, so wrap from all-ones to 0 is legal), go to FETCH.
- Latency: Play sampled at edge n gives FETCH in cycle n+1, LOAD in n+2, PLAY in n+3. The first PBKValid appears the cycle after the first TickEn sampled in PLAY. Minimum word-to-word gap between emissions is 3 cycles (ADVANCE, FETCH, LOAD).
- Play while Busy is ignored. Play and Stop asserted together in IDLE: stay IDLE.
- A word with count = 2^CNT_W-1 emits exactly 2^CNT_W-1 samples.
- EndAddr < StartAddr is legal: the address wraps through 0 to reach EndAddr.
- Loop region consisting only of zero-count words: the sequencer cycles indefinitely with no output and Busy = 1 until Stop or reset.
- Loop may change mid-playback; it takes effect at the next ADVANCE.
- Reset mid-playback returns to the reset values in the following cycle, regardless of other inputs.

Test Plan:
- Memory [0]={0x41,2}, [1]={0x42,1}; StartAddr=0, EndAddr=1, Loop=0, TickEn=1 constant, Play pulsed -> PBK sequence 0x41, 0x41, 0x42, each with a PBKValid pulse; Done pulses once; Busy falls; Address=1.
- Same memory with [1]={0x42,0}, TickEn every 4th cycle -> exactly 2 emissions of 0x41 spaced 4 cycles apart; word 1 produces no PBKValid; Done asserted.
- Loop=1, region 0..1 as in the first test -> PBK repeats 0x41, 0x41, 0x42, 0x41, …; Address returns to 0 after 1; Done never asserted. Stop mid-PLAY -> IDLE next cycle, PBK holds its last value, no further PBKValid.
- ADDR_W=11, StartAddr=0x7FF, EndAddr=0x000, both counts 1 -> Address goes 0x7FF then 0x000; two emissions; Done pulses.
- Play asserted while Busy, and Play+Stop together in IDLE -> no restart and no state change respectively. Reset during PLAY -> all outputs 0, state IDLE next cycle.
- Count field = 15 (CNT_W=4), TickEn=1 -> exactly 15 PBKValid pulses before ADVANCE.

Source files
------------

// File: rtl/playback_sequencer.sv
// -----------------------------------------------------------------------------
// playback_sequencer
//
// Walks a recorded region of sample memory from StartAddr to EndAddr
// (inclusive, wrapping through zero if needed). Each memory word holds
// {sample, repeat count}. The sample is emitted once per TickEn, count times,
// and then the next word is fetched. A count of zero skips the word. The
// region plays once (Done pulses at the end) or loops back to StartAddr.
//
// Ports:
//   PCLK          clock, all logic on the rising edge
//   PBrst         synchronous active-high reset
//   Play          start request, honoured only in IDLE and only without Stop
//   Stop          abort request, returns to IDLE from any busy state
//   Loop          1 = restart at StartAddr after EndAddr, 0 = one-shot
//   TickEn        playback-rate tick, one repeat consumed per tick
//   StartAddr     first word of the region
//   EndAddr       last word of the region (inclusive)
//   SignalFromMem memory read data {sample, count}, 1-cycle read latency
//   Address       registered memory read address
//   PBK           registered sample output, holds between emissions
//   PBKValid      one-cycle pulse in the cycle PBK is updated
//   Busy          high whenever the sequencer is not IDLE
//   Done          one-cycle pulse when a one-shot playback completes
// -----------------------------------------------------------------------------
module playback_sequencer #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4,
    parameter int ADDR_W = 11
) (
    input  logic                     PCLK,
    input  logic                     PBrst,
    input  logic                     Play,
    input  logic                     Stop,
    input  logic                     Loop,
    input  logic                     TickEn,
    input  logic [ADDR_W-1:0]        StartAddr,
    input  logic [ADDR_W-1:0]        EndAddr,
    input  logic [DATA_W+CNT_W-1:0]  SignalFromMem,
    output logic [ADDR_W-1:0]        Address,
    output logic [DATA_W-1:0]        PBK,
    output logic                     PBKValid,
    output logic                     Busy,
    output logic                     Done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY,
        ADVANCE
    } state_t;

    state_t              state_q,  state_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [DATA_W-1:0]   pbk_q,    pbk_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                valid_q,  valid_d;
    logic                done_q,   done_d;

    logic [DATA_W-1:0]   mem_sample;
    logic [CNT_W-1:0]    mem_count;

    assign mem_sample = SignalFromMem[DATA_W+CNT_W-1:CNT_W];
    assign mem_count  = SignalFromMem[CNT_W-1:0];

    // Next-state and datapath logic
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        pbk_d    = pbk_q;
        sample_d = sample_q;
        cnt_d    = cnt_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;

        if (Stop && (state_q != IDLE)) begin
            // Abort: outputs and address hold, no strobes.
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Play && !Stop) begin
                        addr_d  = StartAddr;
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    // Memory read issued on Address; data arrives next cycle.
                    state_d = LOAD;
                end
                LOAD: begin
                    sample_d = mem_sample;
                    cnt_d    = mem_count;
                    state_d  = (mem_count == '0) ? ADVANCE : PLAY;
                end
                PLAY: begin
                    if (TickEn) begin
                        pbk_d   = sample_q;
                        valid_d = 1'b1;
                        cnt_d   = cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = ADVANCE;
                        end
                    end
                end
                ADVANCE: begin
                    if (addr_q == EndAddr) begin
                        if (Loop) begin
                            addr_d  = StartAddr;
                            state_d = FETCH;
                        end else begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        // Natural modulo wrap lets a region cross address 0.
                        addr_d  = addr_q + 1'b1;
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PBrst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            pbk_q    <= '0;
            sample_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            pbk_q    <= pbk_d;
            sample_q <= sample_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign Address  = addr_q;
    assign PBK      = pbk_q;
    assign PBKValid = valid_q;
    assign Done     = done_q;
    assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_playback_sequencer.sv
// -----------------------------------------------------------------------------
// tb_playback_sequencer
//
// Directed bench for playback_sequencer. A scoreboard queue holds the sample
// stream the region must produce (built by walking the bench's memory image);
// a compare process checks PBK on every valid strobe, PBK hold on every other
// cycle, reset values and Done placement. Directed tests add literal timing
// and address expectations.
// -----------------------------------------------------------------------------
module tb_playback_sequencer;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int ADDR_W = 11;
    localparam int MEM_W  = DATA_W + CNT_W;

    logic                PCLK;
    logic                PBrst;
    logic                Play;
    logic                Stop;
    logic                Loop;
    logic                TickEn;
    logic [ADDR_W-1:0]   StartAddr;
    logic [ADDR_W-1:0]   EndAddr;
    logic [MEM_W-1:0]    SignalFromMem;
    logic [ADDR_W-1:0]   Address;
    logic [DATA_W-1:0]   PBK;
    logic                PBKValid;
    logic                Busy;
    logic                Done;

    playback_sequencer #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .PCLK         (PCLK),
        .PBrst        (PBrst),
        .Play         (Play),
        .Stop         (Stop),
        .Loop         (Loop),
        .TickEn       (TickEn),
        .StartAddr    (StartAddr),
        .EndAddr      (EndAddr),
        .SignalFromMem(SignalFromMem),
        .Address      (Address),
        .PBK          (PBK),
        .PBKValid     (PBKValid),
        .Busy         (Busy),
        .Done         (Done)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Recording memory with 1-cycle synchronous read
    logic [MEM_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge PCLK) SignalFromMem <= mem[Address];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int tick_div = 0;          // 0: TickEn always high, 1: every 4th cycle
    int model_pbk = 0;
    int exp_q[$];
    int vt[$];
    int vaddr[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int play_cyc = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, expv, expv, cyc);
        end
    endtask

    // TickEn pacing
    always @(negedge PCLK) begin
        if (tick_div == 0) TickEn = 1'b1;
        else               TickEn = ((cyc % 4) == 0);
    end

    // Compare process: sample #1 after each rising edge
    always begin
        logic rst_e;
        int   e;
        @(posedge PCLK);
        cyc++;
        rst_e = PBrst;
        #1;
        if (rst_e) begin
            chk("rst_pbk",   int'(PBK), 0);
            chk("rst_valid", int'(PBKValid), 0);
            chk("rst_done",  int'(Done), 0);
            chk("rst_busy",  int'(Busy), 0);
            chk("rst_addr",  int'(Address), 0);
            model_pbk = 0;
        end else begin
            if (PBKValid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", int'(PBKValid), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pbk_value", int'(PBK), e);
                    model_pbk = e;
                end
                vt.push_back(cyc);
                vaddr.push_back(int'(Address));
            end else begin
                chk("pbk_hold", int'(PBK), model_pbk);
            end
            if (Done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_after_last", exp_q.size(), 0);
            end
        end
    end

    // Reference walk of the region: every word contributes its sample
    // count times; passes > 1 models loop mode.
    task automatic build_exp(input int start_a, input int end_a, input int passes);
        int a;
        for (int p = 0; p < passes; p++) begin
            a = start_a;
            forever begin
                for (int k = 0; k < int'(mem[a][CNT_W-1:0]); k++)
                    exp_q.push_back(int'(mem[a][MEM_W-1:CNT_W]));
                if (a == end_a) break;
                a = (a + 1) % (1 << ADDR_W);
            end
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    endtask

    task automatic do_reset();
        @(negedge PCLK);
        PBrst = 1'b1;
        @(negedge PCLK);
        PBrst = 1'b0;
        exp_q.delete();
        vt.delete();
        vaddr.delete();
        done_cnt = 0;
        done_cyc = 0;
    endtask

    task automatic start_play();
        @(negedge PCLK);
        Play = 1'b1;
        play_cyc = cyc + 1;
        @(negedge PCLK);
        Play = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int b = 0;
        @(negedge PCLK);
        while (Busy && b < budget) begin
            @(negedge PCLK);
            b++;
        end
        chk("idle_timeout", int'(Busy), 0);
    endtask

    task automatic wait_valids(input int n, input int budget);
        int b = 0;
        while (vt.size() < n && b < budget) begin
            @(negedge PCLK);
            b++;
        end
        chk("valid_timeout", vt.size() >= n ? 1 : 0, 1);
    endtask

    initial begin
        PBrst = 1'b1; Play = 1'b0; Stop = 1'b0; Loop = 1'b0; TickEn = 1'b1;
        StartAddr = '0; EndAddr = '0;
        clear_mem();
        repeat (2) @(negedge PCLK);
        PBrst = 1'b0;

        // ---- 1: one-shot, two words, TickEn constant ----
        do_reset();
        clear_mem();
        mem[0] = {8'h41, 4'd2};
        mem[1] = {8'h42, 4'd1};
        StartAddr = 11'd0; EndAddr = 11'd1; Loop = 1'b0; tick_div = 0;
        build_exp(0, 1, 1);
        chk("t1_model_len", exp_q.size(), 3);
        start_play();
        wait_idle(100);
        chk("t1_n_valid", vt.size(), 3);
        chk("t1_lat0", vt[0] - play_cyc, 3);
        chk("t1_lat1", vt[1] - play_cyc, 4);
        chk("t1_lat2", vt[2] - play_cyc, 8);
        chk("t1_done_at", done_cyc - play_cyc, 9);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_addr", int'(Address), 1);
        chk("t1_pbk_last", int'(PBK), 8'h42);
        $display("t1 one-shot: %0d emissions, done=%0d, addr=%0d", vt.size(), done_cnt, Address);

        // ---- 2: zero-count word, TickEn every 4th cycle ----
        do_reset();
        mem[1] = {8'h42, 4'd0};
        tick_div = 1;
        build_exp(0, 1, 1);
        chk("t2_model_len", exp_q.size(), 2);
        start_play();
        wait_idle(200);
        chk("t2_n_valid", vt.size(), 2);
        if (vt.size() == 2) chk("t2_spacing", vt[1] - vt[0], 4);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_pbk_last", int'(PBK), 8'h41);
        $display("t2 zero-count skip: %0d emissions, done=%0d", vt.size(), done_cnt);

        // ---- 3: loop mode, then Stop mid-PLAY ----
        do_reset();
        mem[1] = {8'h42, 4'd1};
        tick_div = 0; Loop = 1'b1;
        build_exp(0, 1, 3);
        start_play();
        wait_valids(7, 200);
        Stop = 1'b1;
        @(negedge PCLK);
        Stop = 1'b0;
        chk("t3_busy_after_stop", int'(Busy), 0);
        chk("t3_pbk_hold", int'(PBK), 8'h41);
        chk("t3_addr_hold", int'(Address), 0);
        if (vaddr.size() >= 4) begin
            chk("t3_addr_e2", vaddr[2], 1);
            chk("t3_addr_e3", vaddr[3], 0);
        end
        repeat (10) @(negedge PCLK);
        chk("t3_no_more_valid", vt.size(), 7);
        chk("t3_no_done", done_cnt, 0);
        exp_q.delete();
        Loop = 1'b0;
        $display("t3 loop+stop: %0d emissions, done=%0d, pbk=0x%0h", vt.size(), done_cnt, PBK);

        // ---- 4: region wrapping through address 0 ----
        do_reset();
        clear_mem();
        mem[11'h7FF] = {8'hA1, 4'd1};
        mem[11'h000] = {8'hB2, 4'd1};
        StartAddr = 11'h7FF; EndAddr = 11'h000;
        build_exp(11'h7FF, 0, 1);
        chk("t4_model_len", exp_q.size(), 2);
        start_play();
        wait_idle(100);
        chk("t4_n_valid", vt.size(), 2);
        if (vaddr.size() == 2) begin
            chk("t4_addr0", vaddr[0], 11'h7FF);
            chk("t4_addr1", vaddr[1], 0);
        end
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_addr_end", int'(Address), 0);
        $display("t4 wrap: %0d emissions, done=%0d", vt.size(), done_cnt);

        // ---- 5a: Play while Busy ignored ----
        do_reset();
        clear_mem();
        mem[0] = {8'h41, 4'd2};
        mem[1] = {8'h42, 4'd1};
        StartAddr = 11'd0; EndAddr = 11'd1;
        build_exp(0, 1, 1);
        start_play();
        Play = 1'b1;
        repeat (4) @(negedge PCLK);
        Play = 1'b0;
        wait_idle(100);
        chk("t5_n_valid", vt.size(), 3);
        chk("t5_lat2", vt[2] - play_cyc, 8);
        chk("t5_done_cnt", done_cnt, 1);
        $display("t5a play-while-busy: %0d emissions, done=%0d", vt.size(), done_cnt);

        // ---- 5b: Play+Stop together in IDLE ----
        Play = 1'b1; Stop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            chk("t5_playstop_busy", int'(Busy), 0);
            chk("t5_playstop_addr", int'(Address), 1);
        end
        Play = 1'b0; Stop = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("t5_playstop_novalid", vt.size(), 3);
        $display("t5b play+stop in idle: busy=%0d addr=%0d", Busy, Address);

        // ---- 5c: reset during PLAY ----
        do_reset();
        mem[0] = {8'h41, 4'd15};
        EndAddr = 11'd0;
        build_exp(0, 0, 1);
        start_play();
        wait_valids(2, 50);
        PBrst = 1'b1;
        @(negedge PCLK);
        PBrst = 1'b0;
        chk("t5_rst_busy", int'(Busy), 0);
        chk("t5_rst_pbk", int'(PBK), 0);
        chk("t5_rst_addr", int'(Address), 0);
        exp_q.delete();
        repeat (4) @(negedge PCLK);
        chk("t5_rst_novalid", vt.size(), 2);
        $display("t5c reset in play: busy=%0d pbk=0x%0h", Busy, PBK);

        // ---- 6: maximum repeat count ----
        do_reset();
        clear_mem();
        mem[5] = {8'hC3, 4'd15};
        StartAddr = 11'd5; EndAddr = 11'd5;
        build_exp(5, 5, 1);
        chk("t6_model_len", exp_q.size(), 15);
        start_play();
        wait_idle(100);
        chk("t6_n_valid", vt.size(), 15);
        if (vt.size() == 15) begin
            chk("t6_burst", vt[14] - vt[0], 14);
            chk("t6_done_at", done_cyc - vt[14], 1);
        end
        chk("t6_done_cnt", done_cnt, 1);
        $display("t6 count=15: %0d emissions, done=%0d", vt.size(), done_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
